// File: rtl/nco_pkg.sv
// NCO frequency meter shared definitions.
// Default widths, arming threshold and FSM state encoding.
package nco_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int CNT_W_DEF  = 16;
  localparam int HYST_DEF   = 64;

  typedef enum logic {
    SEEK_NEG = 1'b0,
    SEEK_POS = 1'b1
  } arm_st_t;

endpackage

// File: rtl/nco_abs.sv
// Two's-complement magnitude and sign split.
// The most negative input maps to 2^(DATA_W-1) as an unsigned value.
module nco_abs
  import nco_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] i_x,
  output logic        [DATA_W-1:0] o_mag,
  output logic                     o_neg
);

  assign o_neg = i_x[DATA_W-1];
  assign o_mag = o_neg ? -i_x : i_x;

endmodule

// File: rtl/nco_freq_meter.sv
// Measures sine period, peak and direction from an NCO sample stream.
// A crossing is a non-negative sample after arming below -HYST.
module nco_freq_meter
  import nco_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HYST   = HYST_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] fsin_i,
  input  logic signed [DATA_W-1:0] fcos_i,
  output logic        [CNT_W-1:0]  period_o,
  output logic        [DATA_W-1:0] peak_o,
  output logic                     dir_o,
  output logic                     meas_valid_o,
  output logic                     locked_o,
  output logic                     timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic signed [DATA_W-1:0] NEG_HYST = DATA_W'(-HYST);
  localparam logic signed [DATA_W-1:0] ZERO = '0;

  arm_st_t r_st;
  arm_st_t w_st_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_peak;
  logic              r_have_ref;
  logic              r_have_meas;
  logic [CNT_W-1:0]  r_period;
  logic [DATA_W-1:0] r_peak_o;
  logic              r_dir;
  logic              r_meas;
  logic              r_locked;
  logic              r_tmo;

  logic [DATA_W-1:0] w_mag;
  logic              w_neg;
  logic              w_acc;
  logic              w_arm;
  logic              w_cross;
  logic              w_tmo;
  logic              w_arm_go;
  logic              w_cos_pos;
  logic [CNT_W-1:0]  w_period;
  logic              w_close;

  nco_abs #(
    .DATA_W (DATA_W)
  ) u_abs (
    .i_x   (fsin_i),
    .o_mag (w_mag),
    .o_neg (w_neg)
  );

  assign w_acc   = clken & in_valid;
  assign w_arm   = w_acc && (r_st == SEEK_NEG)
                && (fsin_i <= NEG_HYST);
  assign w_cross = w_acc && (r_st == SEEK_POS) && !w_neg;
  // Fire once, on the sample that brings cnt to its ceiling.
  assign w_tmo   = w_acc && !w_cross && (r_cnt == CNT_PRE);
  assign w_arm_go  = w_arm && !w_tmo;
  assign w_cos_pos = (fcos_i >= ZERO);
  assign w_period  = r_cnt + 1'b1;
  assign w_close   = (w_period == r_period)
                  || (w_period == r_period + 1'b1)
                  || (r_period == w_period + 1'b1);

  always_comb begin
    w_st_nxt = r_st;
    unique case (1'b1)
      w_cross:  w_st_nxt = SEEK_NEG;
      w_tmo:    w_st_nxt = SEEK_NEG;
      w_arm_go: w_st_nxt = SEEK_POS;
      default:  w_st_nxt = r_st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st <= SEEK_NEG;
    end else if (clken) begin
      r_st <= w_st_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_peak      <= '0;
      r_have_ref  <= 1'b0;
      r_have_meas <= 1'b0;
      r_period    <= '0;
      r_peak_o    <= '0;
      r_dir       <= 1'b0;
      r_meas      <= 1'b0;
      r_locked    <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_meas <= w_cross && r_have_ref;
      if (w_cross) begin
        r_cnt      <= '0;
        r_peak     <= w_mag;
        r_have_ref <= 1'b1;
        r_tmo      <= 1'b0;
        if (r_have_ref) begin
          r_period    <= w_period;
          r_peak_o    <= r_peak;
          r_dir       <= w_cos_pos;
          r_locked    <= r_have_meas && w_close;
          r_have_meas <= 1'b1;
        end
      end else if (w_acc) begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_mag > r_peak) begin
          r_peak <= w_mag;
        end
        if (w_tmo) begin
          r_tmo       <= 1'b1;
          r_have_ref  <= 1'b0;
          r_have_meas <= 1'b0;
          r_locked    <= 1'b0;
        end
      end
    end
  end

  assign period_o     = r_period;
  assign peak_o       = r_peak_o;
  assign dir_o        = r_dir;
  assign meas_valid_o = r_meas;
  assign locked_o     = r_locked;
  assign timeout_o    = r_tmo;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Directed bench for nco_freq_meter: vector table plus
// NCO, period-32, timeout, gating and reset sequences.
module tb_nco_freq_meter;

  localparam int DW = 14;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] fsin_i = '0;
  logic signed [DW-1:0] fcos_i = '0;
  logic [CW-1:0] period_o;
  logic [DW-1:0] peak_o;
  logic dir_o;
  logic meas_valid_o;
  logic locked_o;
  logic timeout_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit ce;
    bit v;
    int s;
    int c;
    bit meas;
    int per;
    int pk;
    bit dir;
    bit tmo;
    bit lck;
  } vec_t;

  vec_t tbl[25];

  nco_freq_meter #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .HYST   (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .in_valid     (in_valid),
    .fsin_i       (fsin_i),
    .fcos_i       (fcos_i),
    .period_o     (period_o),
    .peak_o       (peak_o),
    .dir_o        (dir_o),
    .meas_valid_o (meas_valid_o),
    .locked_o     (locked_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] outs();
    return {30'd0, meas_valid_o, period_o, peak_o,
            dir_o, timeout_o, locked_o};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic ce, input logic v,
                      input logic signed [DW-1:0] s,
                      input logic signed [DW-1:0] c);
    clken = ce;
    in_valid = v;
    fsin_i = s;
    fcos_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clken = 1'b1;
    in_valid = 1'b0;
    fsin_i = '0;
    fcos_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic void gen(input logic [31:0] ph,
                              output logic signed [DW-1:0] s,
                              output logic signed [DW-1:0] c);
    real a;
    a = 6.283185307179586
      * real'(longint'({32'd0, ph})) / 4294967296.0;
    s = DW'(int'(8191.0 * $sin(a)));
    c = DW'(int'(8191.0 * $cos(a)));
  endfunction

  task automatic run32(input int n0, input int n1,
                       input bit gaps,
                       output int np, output int fn);
    logic signed [DW-1:0] s;
    logic signed [DW-1:0] c;
    np = 0;
    fn = -1;
    for (int n = n0; n <= n1; n++) begin
      if (gaps && (n % 10 == 0)) begin
        repeat (3) begin
          step(1'b0, 1'b1, 14'sd5000, 14'sd0);
          chk("ce0_meas", meas_valid_o, 0);
        end
      end
      if (gaps && (n % 2 == 1)) begin
        step(1'b1, 1'b0, 14'sd5000, 14'sd0);
      end
      gen(32'(n) << 27, s, c);
      step(1'b1, 1'b1, s, c);
      if (meas_valid_o) begin
        np++;
        if (fn < 0) fn = n;
        chk("p32_per", period_o, 32);
        chk("p32_peak", peak_o, 8191);
        if (gaps) begin
          step(1'b0, 1'b1, 14'sd5000, 14'sd0);
          chk("ce0_after", meas_valid_o, 0);
          chk("ce0_hold", period_o, 32);
        end
      end
    end
  endtask

  task automatic nco_run(input logic [31:0] inc,
                         input bit pos);
    logic [31:0] ph;
    logic signed [DW-1:0] s;
    logic signed [DW-1:0] c;
    int per[$];
    int n0;
    int n1;
    int sum;
    do_reset();
    ph = '0;
    n0 = 0;
    n1 = 0;
    for (int n = 0; n < 200; n++) begin
      gen(ph, s, c);
      step(1'b1, 1'b1, s, c);
      ph = ph + inc;
      if (meas_valid_o) begin
        chk("nco_dir", dir_o, pos ? 1'b1 : (c >= 0));
        chk("nco_lock", locked_o, per.size() > 0);
        chk("nco_per34",
            (period_o == 3) || (period_o == 4), 1);
        per.push_back(int'(period_o));
        if (dir_o) n1++;
        else n0++;
      end
    end
    chk("nco_nmeas", per.size() >= 50, 1);
    for (int i = 6; i < per.size(); i++) begin
      sum = 0;
      for (int k = i - 6; k <= i; k++) sum += per[k];
      chk("nco_sum7", sum, 25);
    end
    if (!pos) chk("nco_dir_neg", n0 > n1, 1);
  endtask

  initial begin
    int np;
    int fn;
    logic signed [DW-1:0] s;
    logic signed [DW-1:0] c;

    tbl[0]  = '{1, 0,     0,  0, 0, 0,    0, 0, 0, 0};
    tbl[1]  = '{1, 1,   -63,  0, 0, 0,    0, 0, 0, 0};
    tbl[2]  = '{1, 1,    10,  0, 0, 0,    0, 0, 0, 0};
    tbl[3]  = '{1, 1,   -64,  0, 0, 0,    0, 0, 0, 0};
    tbl[4]  = '{1, 1,    -1,  0, 0, 0,    0, 0, 0, 0};
    tbl[5]  = '{1, 1,     0,  5, 0, 0,    0, 0, 0, 0};
    tbl[6]  = '{1, 1, -8192,  0, 0, 0,    0, 0, 0, 0};
    tbl[7]  = '{1, 1,  -100,  0, 0, 0,    0, 0, 0, 0};
    tbl[8]  = '{1, 1,   300, -3, 1, 3, 8192, 0, 0, 0};
    tbl[9]  = '{1, 1,   -64,  0, 0, 3, 8192, 0, 0, 0};
    tbl[10] = '{0, 1,    50,  1, 0, 3, 8192, 0, 0, 0};
    tbl[11] = '{1, 0,    50,  1, 0, 3, 8192, 0, 0, 0};
    tbl[12] = '{1, 1, -5000,  0, 0, 3, 8192, 0, 0, 0};
    tbl[13] = '{1, 1,     7,  0, 1, 3, 5000, 1, 0, 1};
    tbl[14] = '{1, 1,   -64,  0, 0, 3, 5000, 1, 0, 1};
    tbl[15] = '{1, 1,   -70,  0, 0, 3, 5000, 1, 0, 1};
    tbl[16] = '{1, 1,   -80,  0, 0, 3, 5000, 1, 0, 1};
    tbl[17] = '{1, 1,   -90,  0, 0, 3, 5000, 1, 0, 1};
    tbl[18] = '{1, 1,     0, -1, 1, 5,   90, 0, 0, 0};
    tbl[19] = '{1, 1,   -64,  0, 0, 5,   90, 0, 0, 0};
    tbl[20] = '{1, 1,   -65,  0, 0, 5,   90, 0, 0, 0};
    tbl[21] = '{1, 1,   -66,  0, 0, 5,   90, 0, 0, 0};
    tbl[22] = '{1, 1,   -67,  0, 0, 5,   90, 0, 0, 0};
    tbl[23] = '{1, 1,   -68,  0, 0, 5,   90, 0, 0, 0};
    tbl[24] = '{1, 1,     1,  3, 1, 6,   68, 1, 0, 1};

    do_reset();
    chk("reset", outs(), 0);
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].ce, tbl[i].v,
           DW'(tbl[i].s), DW'(tbl[i].c));
      chk($sformatf("vec%0d", i), outs(),
          {30'd0, tbl[i].meas, CW'(tbl[i].per),
           DW'(tbl[i].pk), tbl[i].dir,
           tbl[i].tmo, tbl[i].lck});
    end

    nco_run(32'h47AE147B, 1'b1);
    nco_run(32'hB851EB85, 1'b0);

    do_reset();
    run32(0, 96, 1'b0, np, fn);
    chk("p32_np", np, 2);
    chk("p32_first", fn, 64);
    chk("p32_lock", locked_o, 1);
    repeat (65534) step(1'b1, 1'b1, 14'sd100, 14'sd0);
    chk("tmo_before", timeout_o, 0);
    step(1'b1, 1'b1, 14'sd100, 14'sd0);
    chk("tmo_set", timeout_o, 1);
    chk("tmo_lock", locked_o, 0);
    run32(1, 31, 1'b0, np, fn);
    chk("tmo_np0", np, 0);
    chk("tmo_hold", timeout_o, 1);
    run32(32, 32, 1'b0, np, fn);
    chk("tmo_np1", np, 0);
    chk("tmo_clr", timeout_o, 0);
    run32(33, 64, 1'b0, np, fn);
    chk("tmo_np2", np, 1);
    chk("tmo_first", fn, 64);
    chk("tmo_lock2", locked_o, 0);

    do_reset();
    run32(0, 96, 1'b1, np, fn);
    chk("gap_np", np, 2);
    chk("gap_first", fn, 64);

    do_reset();
    run32(0, 80, 1'b0, np, fn);
    chk("rst_pre_np", np, 1);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      gen(32'(81 + k) << 27, s, c);
      step(1'b1, 1'b1, s, c);
      chk("rst_out", outs(), 0);
    end
    reset_n = 1'b1;
    run32(81, 127, 1'b0, np, fn);
    chk("rst_np0", np, 0);
    run32(128, 128, 1'b0, np, fn);
    chk("rst_np1", np, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
